// File: rtl/pipe_ctl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctl_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int MUL_CYCLES_DEF = 4;

  typedef enum logic {
    RUN = 1'b0,
    MUL = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the hazard controller's performance statistics.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multicycle-multiply stalls, with saturating stall/flush statistics.
module pipe_hazard_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mul_start,
  input  logic                  ex_branch_taken,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  mul_busy,
  output logic                  mul_done,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [3:0] MCNT_INIT = 4'(MUL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] mcnt, mcnt_nxt;
  logic       load_use;

  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mcnt_nxt    = mcnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mul_busy    = 1'b0;
    mul_done    = 1'b0;

    if (!reset) begin
      // Hold every stage and squash everything while in reset.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          // A taken branch outranks both a multiply start and a load-use stall.
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_mul_start) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            mul_busy    = 1'b1;
            state_nxt   = MUL;
            mcnt_nxt    = MCNT_INIT;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MUL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          mul_busy    = 1'b1;
          mcnt_nxt    = mcnt - 4'd1;
          // mcnt==0 cannot normally occur here; treat it as done so MUL never locks up.
          if (mcnt <= 4'd1) begin
            mul_done  = 1'b1;
            state_nxt = RUN;
            mcnt_nxt  = '0;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_en),
    .count (stall_count)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush | idex_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_pipe_hazard_ctl;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_mul_start, ex_branch_taken;
  logic       pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;
  logic       mul_busy, mul_done;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipe_hazard_ctl #(.MUL_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_is_load      (ex_is_load),
    .ex_rd           (ex_rd),
    .ex_mul_start    (ex_mul_start),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .mul_busy        (mul_busy),
    .mul_done        (mul_done),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       o;
    logic [CNT_W-1:0] s;
    logic [CNT_W-1:0] f;
    int               id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Output vector order: pc ifid idex | ifid_fl idex_fl exmem_fl | busy done
  localparam logic [7:0] O_RST  = 8'b000_111_00;
  localparam logic [7:0] O_NORM = 8'b111_000_00;
  localparam logic [7:0] O_LU   = 8'b001_010_00;
  localparam logic [7:0] O_BR   = 8'b111_110_00;
  localparam logic [7:0] O_MUL  = 8'b000_001_10;
  localparam logic [7:0] O_MDN  = 8'b000_001_11;

  task automatic step(input logic rst_v, input logic ld, input logic [4:0] rd,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic mul, input logic br,
                      input logic [7:0] eo, input int es, input int ef);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v; ex_is_load = ld; ex_rd = rd;
    id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
    ex_mul_start = mul; ex_branch_taken = br;
    e.o = eo; e.s = CNT_W'(es); e.f = CNT_W'(ef); e.id = step_no;
    step_no++;
    q.push_back(e);
  endtask

  task automatic idle(input logic [7:0] eo, input int es, input int ef);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, eo, es, ef);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, mul_busy, mul_done};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL outputs step %0d: got %b expected %b", e.id, act, e.o);
      end
      checks++;
      if (stall_count !== e.s) begin
        errors++;
        $display("FAIL stall_count step %0d: got %0d expected %0d", e.id, stall_count, e.s);
      end
      checks++;
      if (flush_count !== e.f) begin
        errors++;
        $display("FAIL flush_count step %0d: got %0d expected %0d", e.id, flush_count, e.f);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; ex_is_load = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mul_start = 1'b0; ex_branch_taken = 1'b0;

    // Reset outputs and cleared counters
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 0, 0);
    step(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, O_RST, 0, 0);
    idle(O_NORM, 0, 0);

    // Load-use on rs2, then normal flow
    step(1'b1, 1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, O_LU, 0, 0);
    idle(O_NORM, 1, 1);
    // Load to r0 never stalls; unused matching source never stalls
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, O_NORM, 1, 1);
    step(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, O_NORM, 1, 1);
    // Load-use on rs1
    step(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, O_LU, 1, 1);
    idle(O_NORM, 2, 2);

    // Clear counters
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 2, 2);
    idle(O_NORM, 0, 0);

    // Branch taken with a simultaneous load-use hazard
    step(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, O_BR, 0, 0);
    idle(O_NORM, 0, 1);
    // Illegal branch + mul: branch wins, no MUL entry
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_BR, 0, 1);
    idle(O_NORM, 0, 2);

    // Multiply: 4 stall cycles, done on 4th; branch/load-use ignored in MUL
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MUL, 0, 2);
    step(1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, O_MUL, 1, 2);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_MUL, 2, 2);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MDN, 3, 2);
    idle(O_NORM, 4, 2);

    // Reset on the 2nd MUL cycle abandons the multiply
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MUL, 4, 2);
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_RST, 5, 2);
    idle(O_NORM, 0, 0);
    idle(O_NORM, 0, 0);
    idle(O_NORM, 0, 0);

    // 20 consecutive load-use stalls saturate the 4-bit counters at 15
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, O_LU,
           (i < 15) ? i : 15, (i < 15) ? i : 15);
    end
    idle(O_NORM, 15, 15);
    idle(O_NORM, 15, 15);

    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
